// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory-port signals around mem_arbiter
// slave is the arbiter's view; master is the view of whatever drives the requesters and memory.
interface mem_arbiter_if #(
    parameter int XLEN = 32
) ();
    logic              i_req;
    logic [XLEN-1:0]   i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [XLEN-1:0]   i_rdata;

    logic              d_req;
    logic              d_we;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN/8-1:0] d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch vs load/store arbiter for the single memory port; MEM_ARB_FAIRNESS_EN adds fetch anti-starvation
// One transaction in flight: IDLE arbitrates and latches, REQ presents the latch, RSP waits for the response.
module mem_arbiter #(
    parameter int XLEN = 32
`ifdef MEM_ARB_FAIRNESS_EN
    ,
    parameter int MAX_STREAK = 4
`endif
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                owner_d;
    logic                lat_we;
    logic [XLEN-1:0]     lat_addr;
    logic [XLEN-1:0]     lat_wdata;
    logic [XLEN/8-1:0]   lat_be;
    logic                load_req;
    logic                pick_d;
    logic                rsp_done;
    logic                fetch_turn;
    logic                i_rvalid_q;
    logic                d_rvalid_q;
    logic [XLEN-1:0]     i_rdata_q;
    logic [XLEN-1:0]     d_rdata_q;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    logic [3:0] streak;

    // Counts data wins taken while fetch was waiting; at the limit fetch gets one turn.
    assign fetch_turn = bus.i_req && (streak == STREAK_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (load_req) begin
            if (!bus.i_req || !pick_d) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end
        end
    end
`else
    assign fetch_turn = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        pick_d    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    load_req  = 1'b1;
                    pick_d    = bus.d_req && !fetch_turn;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (bus.mem_rvalid) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_nxt;
            i_rvalid_q <= rsp_done && !owner_d;
            d_rvalid_q <= rsp_done && owner_d;
            if (rsp_done && !owner_d) begin
                i_rdata_q <= bus.mem_rdata;
            end
            if (rsp_done && owner_d) begin
                d_rdata_q <= bus.mem_rdata;
            end
            if (load_req) begin
                owner_d <= pick_d;
                if (pick_d) begin
                    lat_we    <= bus.d_we;
                    lat_addr  <= bus.d_addr;
                    lat_wdata <= bus.d_wdata;
                    lat_be    <= bus.d_be;
                end else begin
                    // Fetch is always a full-word read.
                    lat_we    <= 1'b0;
                    lat_addr  <= bus.i_addr;
                    lat_wdata <= '0;
                    lat_be    <= '1;
                end
            end
        end
    end

    assign bus.mem_req   = (state == REQ);
    assign bus.mem_we    = lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_be    = lat_be;

    assign bus.i_gnt     = (state == REQ) && bus.mem_gnt && !owner_d;
    assign bus.d_gnt     = (state == REQ) && bus.mem_gnt && owner_d;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter: transaction-level model plus directed vectors
module tb_mem_arbiter;
    localparam int XLEN = 32;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam int MAX_STREAK = 4;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();
    mem_arbiter #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rsp_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        own_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        m_txn    = '0;
    int          m_stage  = 0;   // 0 nothing held, 1 offered to memory, 2 accepted and awaiting data
    logic        m_irv    = 1'b0;
    logic        m_drv    = 1'b0;
    logic [31:0] m_irdata = '0;
    logic [31:0] m_drdata = '0;
    bit          m_dknown = 1'b1;
    logic [1:0]  hist[$];        // per arbitration: {data won, fetch was waiting}

    function automatic int d_run();
        int r = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] == 2'b11) r++;
            else break;
        end
        return r;
    endfunction

    initial begin
        logic win_d;
        forever begin
            @(negedge clk);
            if (reset) begin
                check_bit("rst mem_req", bus.mem_req, 1'b0);
                check_bit("rst mem_we", bus.mem_we, 1'b0);
                check("rst mem_addr", bus.mem_addr, 32'h0);
                check("rst mem_wdata", bus.mem_wdata, 32'h0);
                check("rst mem_be", 32'(bus.mem_be), 32'h0);
                check_bit("rst i_gnt", bus.i_gnt, 1'b0);
                check_bit("rst d_gnt", bus.d_gnt, 1'b0);
                check_bit("rst i_rvalid", bus.i_rvalid, 1'b0);
                check_bit("rst d_rvalid", bus.d_rvalid, 1'b0);
                check("rst i_rdata", bus.i_rdata, 32'h0);
                check("rst d_rdata", bus.d_rdata, 32'h0);
                m_stage  = 0;
                m_txn    = '0;
                m_irv    = 1'b0;
                m_drv    = 1'b0;
                m_irdata = '0;
                m_drdata = '0;
                m_dknown = 1'b1;
                hist.delete();
            end else begin
                check_bit("mdl mem_req", bus.mem_req, m_stage == 1);
                if (m_stage == 1) begin
                    check("mdl mem_addr", bus.mem_addr, m_txn.addr);
                    check_bit("mdl mem_we", bus.mem_we, m_txn.we);
                    if (m_txn.own_d) begin
                        check("mdl mem_wdata", bus.mem_wdata, m_txn.wdata);
                        check("mdl mem_be", 32'(bus.mem_be), 32'(m_txn.be));
                    end
                end
                check_bit("mdl i_gnt", bus.i_gnt, m_stage == 1 && bus.mem_gnt && !m_txn.own_d);
                check_bit("mdl d_gnt", bus.d_gnt, m_stage == 1 && bus.mem_gnt && m_txn.own_d);
                check_bit("mdl i_rvalid", bus.i_rvalid, m_irv);
                check_bit("mdl d_rvalid", bus.d_rvalid, m_drv);
                check("mdl i_rdata", bus.i_rdata, m_irdata);
                if (m_dknown) check("mdl d_rdata", bus.d_rdata, m_drdata);

                m_irv = (m_stage == 2) && bus.mem_rvalid && !m_txn.own_d;
                m_drv = (m_stage == 2) && bus.mem_rvalid && m_txn.own_d;
                if (m_irv) m_irdata = bus.mem_rdata;
                if (m_drv) begin
                    m_dknown = !m_txn.we;
                    m_drdata = bus.mem_rdata;
                end
                case (m_stage)
                    0: if (bus.i_req || bus.d_req) begin
                        win_d = bus.d_req;
`ifdef MEM_ARB_FAIRNESS_EN
                        if (bus.d_req && bus.i_req && d_run() >= MAX_STREAK) win_d = 1'b0;
`endif
                        hist.push_back({win_d, bus.i_req});
                        m_txn.own_d = win_d;
                        m_txn.we    = win_d ? bus.d_we : 1'b0;
                        m_txn.addr  = win_d ? bus.d_addr : bus.i_addr;
                        m_txn.wdata = bus.d_wdata;
                        m_txn.be    = bus.d_be;
                        m_stage     = 1;
                    end
                    1: if (bus.mem_gnt) m_stage = 2;
                    default: if (bus.mem_rvalid) m_stage = 0;
                endcase
            end
        end
    end

    // ---------------- automatic memory responder ----------------
    bit          auto_mem  = 1'b0;
    int          gnt_delay = 0;
    int          wait_n    = 0;
    bit          rsp_due   = 1'b0;
    logic [31:0] rsp_addr  = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_mem) begin
                bus.mem_gnt    = 1'b0;
                bus.mem_rvalid = 1'b0;
                if (rsp_due) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rsp_word(rsp_addr);
                    rsp_due        = 1'b0;
                end else if (bus.mem_req) begin
                    if (wait_n >= gnt_delay) begin
                        bus.mem_gnt = 1'b1;
                        rsp_due     = 1'b1;
                        rsp_addr    = bus.mem_addr;
                        wait_n      = 0;
                    end else begin
                        wait_n++;
                    end
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic wait_gnt(input bit is_d, input int limit, output int at, output logic [31:0] addr);
        at   = -1;
        addr = '0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_gnt : bus.i_gnt) begin
                at   = cyc;
                addr = bus.mem_addr;
                break;
            end
        end
        n_vec++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s_gnt timeout: got none, expected within %0d cycles", is_d ? "d" : "i", limit);
        end else begin
            tick();
            if (is_d) bus.d_req = 1'b0;
            else bus.i_req = 1'b0;
        end
    endtask

    task automatic wait_rvalid(input bit is_d, input int limit, output int at, output logic [31:0] data);
        at   = -1;
        data = '0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_rvalid : bus.i_rvalid) begin
                at   = cyc;
                data = is_d ? bus.d_rdata : bus.i_rdata;
                break;
            end
        end
        n_vec++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s_rvalid timeout: got none, expected within %0d cycles", is_d ? "d" : "i", limit);
        end
    endtask

    initial begin
        #200000;
        n_vec++;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int          c_a, c_b;
        logic [31:0] v;
        string       seq;
        int          got;
        int          n_i;

        reset          = 1'b1;
        bus.i_req      = 1'b0;
        bus.i_addr     = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_be       = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        repeat (2) @(posedge clk);
        settle();
        check_bit("t0 reset mem_req", bus.mem_req, 1'b0);
        check_bit("t0 reset i_rvalid", bus.i_rvalid, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Fetch 0x100, zero wait states
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        tick();
        bus.mem_gnt = 1'b1;
        settle();
        check_bit("t1 mem_req c1", bus.mem_req, 1'b1);
        check("t1 mem_addr c1", bus.mem_addr, 32'h100);
        check_bit("t1 i_gnt c1", bus.i_gnt, 1'b1);
        check_bit("t1 d_gnt c1", bus.d_gnt, 1'b0);
        tick();
        bus.i_req      = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0013;
        settle();
        check_bit("t1 i_gnt c2", bus.i_gnt, 1'b0);
        check_bit("t1 i_rvalid c2", bus.i_rvalid, 1'b0);
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        settle();
        check_bit("t1 i_rvalid c3", bus.i_rvalid, 1'b1);
        check("t1 i_rdata c3", bus.i_rdata, 32'h13);
        check_bit("t1 d_rvalid c3", bus.d_rvalid, 1'b0);
        tick();
        settle();
        check_bit("t1 i_rvalid c4", bus.i_rvalid, 1'b0);

        // Simultaneous requests: data first, fetch after the data response
        auto_mem  = 1'b1;
        gnt_delay = 0;
        tick();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h2000;
        bus.d_be    = 4'hF;
        bus.d_wdata = '0;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h300;
        wait_gnt(1'b1, 20, c_a, v);
        check("t2 first grant addr", v, 32'h2000);
        wait_rvalid(1'b1, 20, c_a, v);
        check("t2 load data", v, 32'h2000_DFFF);
        wait_gnt(1'b0, 20, c_b, v);
        check("t2 fetch grant addr", v, 32'h300);
        check_bit("t2 fetch after data rsp", c_b > c_a, 1'b1);
        wait_rvalid(1'b0, 20, c_b, v);
        check("t2 fetch data", v, rsp_word(32'h300));

        // Store with three memory wait states
        auto_mem = 1'b0;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.d_req      = 1'b1;
        bus.d_we       = 1'b1;
        bus.d_addr     = 32'h40;
        bus.d_wdata    = 32'hDEAD_BEEF;
        bus.d_be       = 4'b0011;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.mem_gnt    = (k == 4);
            bus.mem_rvalid = (k == 2);
            if (k == 2) bus.d_req = 1'b0;
            settle();
            check_bit("t3 mem_req", bus.mem_req, 1'b1);
            check_bit("t3 mem_we", bus.mem_we, 1'b1);
            check("t3 mem_addr", bus.mem_addr, 32'h40);
            check("t3 mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            check("t3 mem_be", 32'(bus.mem_be), 32'h3);
            check_bit("t3 d_gnt", bus.d_gnt, k == 4);
            check_bit("t3 d_rvalid early", bus.d_rvalid, 1'b0);
        end
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_F00D;
        settle();
        check_bit("t3 d_gnt rsp", bus.d_gnt, 1'b0);
        check_bit("t3 d_rvalid c5", bus.d_rvalid, 1'b0);
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b1;
        settle();
        check_bit("t3 d_rvalid c6", bus.d_rvalid, 1'b1);
        check_bit("t3 i_rvalid c6", bus.i_rvalid, 1'b0);
        tick();
        bus.mem_gnt = 1'b0;
        settle();
        check_bit("t3 stray gnt no req", bus.mem_req, 1'b0);
        check_bit("t3 d_rvalid c7", bus.d_rvalid, 1'b0);

        // Asynchronous reset during RSP
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h500;
        tick();
        bus.mem_gnt = 1'b1;
        tick();
        bus.i_req   = 1'b0;
        bus.mem_gnt = 1'b0;
        settle();
        #2;
        reset = 1'b1;
        #1;
        check_bit("t4 async mem_req", bus.mem_req, 1'b0);
        check("t4 async mem_addr", bus.mem_addr, 32'h0);
        check("t4 async mem_be", 32'(bus.mem_be), 32'h0);
        check("t4 async i_rdata", bus.i_rdata, 32'h0);
        check("t4 async d_rdata", bus.d_rdata, 32'h0);
        check_bit("t4 async i_gnt", bus.i_gnt, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tick();
        reset          = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        settle();
        check_bit("t4 late rsp i_rvalid", bus.i_rvalid, 1'b0);
        check_bit("t4 late rsp d_rvalid", bus.d_rvalid, 1'b0);
        rsp_due  = 1'b0;
        wait_n   = 0;
        auto_mem = 1'b1;
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h600;
        wait_gnt(1'b0, 20, c_a, v);
        check("t4 post reset fetch addr", v, 32'h600);
        wait_rvalid(1'b0, 20, c_a, v);
        check("t4 post reset fetch data", v, rsp_word(32'h600));

        // Both requesters held continuously
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h700;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h800;
        bus.d_be   = 4'hF;
        seq = "";
        got = 0;
        n_i = 0;
        for (int k = 0; k < 200 && got < 20; k++) begin
            @(negedge clk);
            if (bus.i_gnt) begin
                seq = {seq, "I"};
                got++;
                n_i++;
            end
            if (bus.d_gnt) begin
                seq = {seq, "D"};
                got++;
            end
        end
        check("t5 grants seen", 32'(got), 32'd20);
`ifdef MEM_ARB_FAIRNESS_EN
        check_str("t5 grant order", seq.substr(0, 9), "DDDDIDDDDI");
`else
        check("t5 fetch grants", 32'(n_i), 32'd0);
`endif
        tick();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
